led_mode_sel: RTL and testbench

Selects which LED pattern driver (breath, chase, etc.) owns the 8-LED bank. A debounced push-button advances the active mode. The block muxes the selected driver's 8-bit pattern onto the pins and holds every non-selected driver in reset, so each mode starts from its own reset state on entry. It sits between the raw key input, the per-mode LED drivers and the LED pins.

---
 rtl/led_mode_sel_if.sv | 25 ++
 rtl/led_mode_sel.sv | 166 ++++++++++++++++
 tb/tb_led_mode_sel.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/led_mode_sel_if.sv
// Signal bundle between the LED mode selector, its key input, the per-mode
// pattern drivers and the LED pins.
interface led_mode_sel_if;
  logic        key_n;
  logic [31:0] mode_led_bus;
  logic [3:0]  drv_rst_n;
  logic [1:0]  mode;
  logic [7:0]  led_out;

  modport master (
    output key_n,
    output mode_led_bus,
    input  drv_rst_n,
    input  mode,
    input  led_out
  );

  modport slave (
    input  key_n,
    input  mode_led_bus,
    output drv_rst_n,
    output mode,
    output led_out
  );
endinterface

// File: rtl/led_mode_sel.sv
// LED mode selector: debounced key advances the mode, muxes the selected driver's
// pattern onto the pins and holds the other drivers in reset. Optional: LED_MODE_SEL_AUTO_EN.
module led_mode_sel #(
  parameter int N_MODES         = 4,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SWRST_CYCLES    = 4,
  parameter int AUTO_PERIOD     = 1000000
) (
  input logic           clk,
  input logic           rst_n,
  led_mode_sel_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int SW = $clog2(SWRST_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST        = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SW_INIT_LAST   = SW'(SWRST_CYCLES);
  localparam logic [SW-1:0] SW_SWITCH_LAST = SW'(SWRST_CYCLES - 1);
  localparam logic [1:0]    MODE_LAST      = 2'(N_MODES - 1);
  localparam logic [3:0]    DRV_MASK       = 4'((1 << N_MODES) - 1);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_SWITCH = 2'd2
  } state_t;

  state_t        state_r, state_nxt;
  logic [1:0]    mode_r, mode_nxt;
  logic [SW-1:0] sw_cnt_r, sw_cnt_nxt;
  logic [3:0]    drv_r, drv_nxt;
  logic [7:0]    led_r, led_nxt;

  logic          key_meta_r, key_sync_r, key_stable_r;
  logic [DW-1:0] db_cnt_r;
  logic          press_s, auto_hit_s, advance_s;
  logic [1:0]    next_mode_s;

  function automatic logic [3:0] drv_one_hot(input logic [1:0] m);
    drv_one_hot = (4'b0001 << m) & DRV_MASK;
  endfunction

  // Key synchronizer and debounce filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_r   <= 1'b1;
      key_sync_r   <= 1'b1;
      key_stable_r <= 1'b1;
      db_cnt_r     <= {DW{1'b0}};
    end else begin
      key_meta_r <= bus.key_n;
      key_sync_r <= key_meta_r;
      if (key_sync_r == key_stable_r) begin
        db_cnt_r <= {DW{1'b0}};
      end else if (db_cnt_r == DB_LAST) begin
        key_stable_r <= key_sync_r;
        db_cnt_r     <= {DW{1'b0}};
      end else begin
        db_cnt_r <= db_cnt_r + {{(DW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Only the falling edge of the filtered key is an event.
  assign press_s = (key_sync_r != key_stable_r) && (db_cnt_r == DB_LAST) &&
                   (key_sync_r == 1'b0);

`ifdef LED_MODE_SEL_AUTO_EN
  localparam logic [23:0] AUTO_LAST = 24'(AUTO_PERIOD - 1);
  logic [23:0] auto_cnt_r;

  assign auto_hit_s = (state_r == ST_RUN) && (auto_cnt_r == AUTO_LAST);

  // Auto-advance timer: runs only in RUN, restarts on every advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt_r <= 24'd0;
    end else if ((state_r != ST_RUN) || advance_s) begin
      auto_cnt_r <= 24'd0;
    end else begin
      auto_cnt_r <= auto_cnt_r + 24'd1;
    end
  end
`else
  assign auto_hit_s = 1'b0;
`endif

  assign advance_s   = (state_r == ST_RUN) && (press_s || auto_hit_s);
  assign next_mode_s = (mode_r == MODE_LAST) ? 2'd0 : (mode_r + 2'd1);

  // Mode FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_INIT;
      mode_r   <= 2'd0;
      sw_cnt_r <= {SW{1'b0}};
      drv_r    <= 4'b0000;
      led_r    <= 8'h00;
    end else begin
      state_r  <= state_nxt;
      mode_r   <= mode_nxt;
      sw_cnt_r <= sw_cnt_nxt;
      drv_r    <= drv_nxt;
      led_r    <= led_nxt;
    end
  end

  // Next-state logic. INIT counts one extra cycle so the first edge after
  // reset release is spent leaving reset, matching the documented release timing.
  always_comb begin
    state_nxt  = state_r;
    mode_nxt   = mode_r;
    sw_cnt_nxt = sw_cnt_r;
    drv_nxt    = drv_r;
    led_nxt    = led_r;
    case (state_r)
      ST_INIT: begin
        led_nxt = 8'h00;
        drv_nxt = 4'b0000;
        if (sw_cnt_r == SW_INIT_LAST) begin
          state_nxt  = ST_RUN;
          sw_cnt_nxt = {SW{1'b0}};
          drv_nxt    = drv_one_hot(mode_r);
        end else begin
          sw_cnt_nxt = sw_cnt_r + {{(SW-1){1'b0}}, 1'b1};
        end
      end
      ST_RUN: begin
        led_nxt = bus.mode_led_bus[{mode_r, 3'b000} +: 8];
        drv_nxt = drv_one_hot(mode_r);
        if (advance_s) begin
          state_nxt  = ST_SWITCH;
          mode_nxt   = next_mode_s;
          sw_cnt_nxt = {SW{1'b0}};
          drv_nxt    = 4'b0000;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_SWITCH: begin
        led_nxt = 8'h00;
        drv_nxt = 4'b0000;
        if (sw_cnt_r == SW_SWITCH_LAST) begin
          state_nxt  = ST_RUN;
          sw_cnt_nxt = {SW{1'b0}};
          drv_nxt    = drv_one_hot(mode_r);
        end else begin
          sw_cnt_nxt = sw_cnt_r + {{(SW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt  = ST_INIT;
        mode_nxt   = 2'd0;
        sw_cnt_nxt = {SW{1'b0}};
        drv_nxt    = 4'b0000;
        led_nxt    = 8'h00;
      end
    endcase
  end

  assign bus.drv_rst_n = drv_r;
  assign bus.mode      = mode_r;
  assign bus.led_out   = led_r;

endmodule

// File: tb/tb_led_mode_sel.sv
// Self-checking bench for led_mode_sel: directed reset/press/bounce/wrap/reset-mid-switch
// steps, a randomized press phase against a mode-counting model, and a switch-drop check.
module tb_led_mode_sel;

  localparam logic [31:0] BUS_INIT = 32'h44332211;

  logic clk = 1'b0;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  led_mode_sel_if if0 ();
  led_mode_sel_if if2 ();

  led_mode_sel #(.N_MODES(4), .DEBOUNCE_CYCLES(8), .SWRST_CYCLES(4), .AUTO_PERIOD(50)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if0.slave)
  );

  // Short debounce with long blanking, so a second press can land inside SWITCH.
  led_mode_sel #(.N_MODES(4), .DEBOUNCE_CYCLES(2), .SWRST_CYCLES(16), .AUTO_PERIOD(1000000)) dut_drop (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if2.slave)
  );

  function automatic logic [7:0] slice_of(input logic [31:0] b, input int m);
    logic [31:0] sh;
    sh = b >> (8 * m);
    return sh[7:0];
  endfunction

  function automatic logic [3:0] onehot(input int m);
    return 4'(1 << m);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      fails = fails + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outs(input string tag, input int m, input logic [7:0] led);
    check({tag, ".mode"}, 32'(if0.mode), 32'(m));
    check({tag, ".drv"},  32'(if0.drv_rst_n), 32'(onehot(m)));
    check({tag, ".led"},  32'(if0.led_out), 32'(led));
  endtask

  // Called on the negedge where rst_n was released.
  task automatic init_sequence(input string tag);
    tick(4);
    check({tag, ".drv_e4"}, 32'(if0.drv_rst_n), 32'h0);
    tick(1);
    check({tag, ".drv_e5"}, 32'(if0.drv_rst_n), 32'h1);
    check({tag, ".led_e5"}, 32'(if0.led_out), 32'h0);
    check({tag, ".mode_e5"}, 32'(if0.mode), 32'h0);
    tick(1);
    check({tag, ".led_e6"}, 32'(if0.led_out), 32'h11);
  endtask

  task automatic clean_press(input int from);
    int nm;
    nm = (from + 1) % 4;
    if0.key_n = 1'b0;
    tick(9);
    check("press.mode_early", 32'(if0.mode), 32'(from));
    tick(1);
    check("press.mode_new", 32'(if0.mode), 32'(nm));
    check("press.drv_off", 32'(if0.drv_rst_n), 32'h0);
    tick(1);
    check("press.blank1", 32'(if0.led_out), 32'h0);
    tick(3);
    check("press.blank4", 32'(if0.led_out), 32'h0);
    check("press.drv_on", 32'(if0.drv_rst_n), 32'(onehot(nm)));
    tick(1);
    check("press.led_new", 32'(if0.led_out), 32'(slice_of(BUS_INIT, nm)));
    tick(5);
    if0.key_n = 1'b1;
    tick(25);
    check_outs("press.after_release", nm, slice_of(BUS_INIT, nm));
  endtask

  initial begin
    int          exp_mode;
    logic [31:0] rbus;
    rst_n = 1'b0;
    if0.key_n = 1'b1;
    if2.key_n = 1'b1;
    if0.mode_led_bus = BUS_INIT;
    if2.mode_led_bus = BUS_INIT;
    tick(3);
    check("reset.mode", 32'(if0.mode), 32'h0);
    check("reset.drv",  32'(if0.drv_rst_n), 32'h0);
    check("reset.led",  32'(if0.led_out), 32'h0);
    rst_n = 1'b1;
    init_sequence("init");

`ifdef LED_MODE_SEL_AUTO_EN
    // RUN entered on edge 5 after release; advances land on edges 55, 109, 163, 217.
    tick(48);
    check("auto.mode_e54", 32'(if0.mode), 32'h0);
    tick(1);
    check("auto.mode_e55", 32'(if0.mode), 32'h1);
    check("auto.drv_e55", 32'(if0.drv_rst_n), 32'h0);
    tick(53);
    check("auto.mode_e108", 32'(if0.mode), 32'h1);
    tick(1);
    check("auto.mode_e109", 32'(if0.mode), 32'h2);
    tick(44);
    if0.key_n = 1'b0;
    tick(10);
    check("auto.coincide", 32'(if0.mode), 32'h3);
    tick(2);
    if0.key_n = 1'b1;
    tick(5);
    check("auto.single_adv", 32'(if0.mode), 32'h3);
    tick(46);
    check("auto.mode_e216", 32'(if0.mode), 32'h3);
    tick(1);
    check("auto.mode_e217", 32'(if0.mode), 32'h0);
    tick(5);
    check_outs("auto.settled", 0, 8'h11);
`else
    clean_press(0);

    repeat (3) begin
      if0.key_n = 1'b0;
      tick(5);
      if0.key_n = 1'b1;
      tick(3);
    end
    tick(20);
    check_outs("bounce", 1, 8'h22);

    clean_press(1);
    clean_press(2);
    clean_press(3);
    check_outs("wrap", 0, 8'h11);

    // Randomized presses: only holds longer than the debounce window count.
    exp_mode = 0;
    for (int i = 0; i < 8; i++) begin
      if0.key_n = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        tick($urandom_range(12, 19));
        exp_mode = (exp_mode + 1) % 4;
      end else begin
        tick($urandom_range(1, 6));
      end
      if0.key_n = 1'b1;
      tick(30);
      rbus = $urandom;
      if0.mode_led_bus = rbus;
      tick(1);
      check_outs("rand", exp_mode, slice_of(rbus, exp_mode));
    end
    if0.mode_led_bus = BUS_INIT;
    tick(1);
    if (exp_mode == 3) begin
      clean_press(3);
      exp_mode = 0;
    end

    // Reset in the middle of SWITCH.
    if0.key_n = 1'b0;
    tick(10);
    check("midsw.mode_adv", 32'(if0.mode), 32'(exp_mode + 1));
    tick(2);
    if0.key_n = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midsw.mode_rst", 32'(if0.mode), 32'h0);
    check("midsw.drv_rst",  32'(if0.drv_rst_n), 32'h0);
    check("midsw.led_rst",  32'(if0.led_out), 32'h0);
    tick(2);
    rst_n = 1'b1;
    init_sequence("reinit");

    // A second press completing inside SWITCH must be dropped.
    tick(30);
    if2.key_n = 1'b0;
    tick(4);
    check("drop.first", 32'(if2.mode), 32'h1);
    tick(1);
    if2.key_n = 1'b1;
    tick(5);
    if2.key_n = 1'b0;
    tick(4);
    check("drop.in_switch", 32'(if2.mode), 32'h1);
    check("drop.drv_off", 32'(if2.drv_rst_n), 32'h0);
    tick(2);
    if2.key_n = 1'b1;
    tick(40);
    check("drop.mode_final", 32'(if2.mode), 32'h1);
    check("drop.drv_final", 32'(if2.drv_rst_n), 32'h2);
    check("drop.led_final", 32'(if2.led_out), 32'h22);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
